// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter: FSM states,
// requester identity, default widths and the burst-counter helper.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W         = 26;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_MAX_BURST      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int BURST_CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    WR_ISSUE = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } requester_t;

  // Burst counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
    logic [BURST_CNT_W-1:0] r;
    if (v == {BURST_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_picker.sv
// Round-robin selector with a per-requester burst cap. The selection is
// combinational from the live requests; last_served and burst_cnt are
// updated on every grant event reported by the arbiter FSM.
module rr_burst_picker
  import sdram_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_rd_req,
  input  logic       i_wr_req,
  input  logic       i_grant_evt,
  input  requester_t i_grant_who,
  output logic       o_sel_valid,
  output requester_t o_sel
);

  localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

  requester_t             r_last_served;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic                   w_hold;

  // A zero count means nobody has been served since reset, so there is no
  // burst in progress and the tie goes to the requester not last served.
  assign w_hold = (r_burst_cnt != {BURST_CNT_W{1'b0}}) && (r_burst_cnt < MAX_BURST_C);

  // Pick the next requester from the current requests and burst history.
  always_comb begin
    o_sel_valid = 1'b0;
    o_sel       = REQ_RD;
    if (i_rd_req && i_wr_req) begin
      o_sel_valid = 1'b1;
      if (w_hold) begin
        o_sel = r_last_served;
      end else if (r_last_served == REQ_RD) begin
        o_sel = REQ_WR;
      end else begin
        o_sel = REQ_RD;
      end
    end else if (i_rd_req) begin
      o_sel_valid = 1'b1;
      o_sel       = REQ_RD;
    end else if (i_wr_req) begin
      o_sel_valid = 1'b1;
      o_sel       = REQ_WR;
    end else begin
      o_sel_valid = 1'b0;
      o_sel       = REQ_RD;
    end
  end

  // Track who was granted last and how many consecutive grants it received.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_last_served <= REQ_WR;
      r_burst_cnt   <= {BURST_CNT_W{1'b0}};
    end else if (i_grant_evt) begin
      if (i_grant_who == r_last_served) begin
        r_burst_cnt <= sat_inc(r_burst_cnt);
      end else begin
        r_burst_cnt   <= {{(BURST_CNT_W-1){1'b0}}, 1'b1};
        r_last_served <= i_grant_who;
      end
    end else begin
      r_burst_cnt   <= r_burst_cnt;
      r_last_served <= r_last_served;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM port between the row-cache read path and the
// filter-result write path. Commands, address, data, grants and busy are
// all registered. Optional watchdog: define SDRAM_ARB_TIMEOUT_EN to abort
// an access that sees no ack within TIMEOUT_CYCLES and flag o_timeout_err.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_BURST      = DEF_MAX_BURST,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [DATA_W-1:0] o_sdram_wdata,
  output logic              o_sdram_read_en,
  output logic              o_sdram_write_en,
  input  logic [DATA_W-1:0] i_sdram_rdata,
  input  logic              i_sdram_ack,
`ifdef SDRAM_ARB_TIMEOUT_EN
  output logic              o_timeout_err,
`endif
  output logic              o_busy
);

  arb_state_t        r_state;
  logic              r_rd_gnt;
  logic              r_wr_gnt;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_sdram_addr;
  logic [DATA_W-1:0] r_sdram_wdata;
  logic              r_read_en;
  logic              r_write_en;
  logic              r_busy;

  logic       w_issue;
  logic       w_timeout;
  logic       w_grant_evt;
  requester_t w_grant_who;
  logic       w_sel_valid;
  requester_t w_sel;

  assign w_issue     = (r_state == RD_ISSUE) || (r_state == WR_ISSUE);
  assign w_grant_evt = w_issue && (i_sdram_ack || w_timeout);
  assign w_grant_who = (r_state == WR_ISSUE) ? REQ_WR : REQ_RD;

  rr_burst_picker #(
    .MAX_BURST (MAX_BURST)
  ) u_picker (
    .i_clk       (i_clk),
    .i_n_rst     (i_n_rst),
    .i_rd_req    (i_rd_req),
    .i_wr_req    (i_wr_req),
    .i_grant_evt (w_grant_evt),
    .i_grant_who (w_grant_who),
    .o_sel_valid (w_sel_valid),
    .o_sel       (w_sel)
  );

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_err;

  // The command has been up for TIMEOUT_CYCLES cycles when the counter
  // reaches its last value with still no ack.
  assign w_timeout = w_issue && !i_sdram_ack && (r_wdog == WD_LAST);

  // Count cycles spent waiting in an issue state; clear otherwise.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_wdog <= {WD_W{1'b0}};
    end else if (w_issue && !w_grant_evt) begin
      r_wdog <= r_wdog + WD_W'(1);
    end else begin
      r_wdog <= {WD_W{1'b0}};
    end
  end

  // Flag an aborted access for one cycle, aligned with its grant pulse.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  // Arbiter FSM: select, issue and hold the command, then grant for one cycle.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state       <= IDLE;
      r_rd_gnt      <= 1'b0;
      r_wr_gnt      <= 1'b0;
      r_rd_data     <= {DATA_W{1'b0}};
      r_sdram_addr  <= {ADDR_W{1'b0}};
      r_sdram_wdata <= {DATA_W{1'b0}};
      r_read_en     <= 1'b0;
      r_write_en    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rd_gnt <= 1'b0;
      r_wr_gnt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sel_valid && (w_sel == REQ_RD)) begin
            r_state      <= RD_ISSUE;
            r_sdram_addr <= i_rd_addr;
            r_read_en    <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_sel_valid) begin
            r_state       <= WR_ISSUE;
            r_sdram_addr  <= i_wr_addr;
            r_sdram_wdata <= i_wr_data;
            r_write_en    <= 1'b1;
            r_busy        <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (w_grant_evt) begin
            r_state   <= DONE;
            r_read_en <= 1'b0;
            r_rd_gnt  <= 1'b1;
            r_rd_data <= w_timeout ? {DATA_W{1'b0}} : i_sdram_rdata;
          end else begin
            r_read_en <= 1'b1;
          end
        end
        WR_ISSUE: begin
          if (w_grant_evt) begin
            r_state    <= DONE;
            r_write_en <= 1'b0;
            r_wr_gnt   <= 1'b1;
          end else begin
            r_write_en <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_read_en  <= 1'b0;
          r_write_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_gnt         = r_rd_gnt;
  assign o_wr_gnt         = r_wr_gnt;
  assign o_rd_data        = r_rd_data;
  assign o_sdram_addr     = r_sdram_addr;
  assign o_sdram_wdata    = r_sdram_wdata;
  assign o_sdram_read_en  = r_read_en;
  assign o_sdram_write_en = r_write_en;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. Outputs are sampled on the falling
// edge; inputs change on the falling edge. The watchdog scenario is built
// only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_port_arbiter;

  localparam int ADDR_W         = 26;
  localparam int DATA_W         = 32;
  localparam int MAX_BURST      = 8;
  localparam int TIMEOUT_CYCLES = 64;

  logic              clk;
  logic              n_rst;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wdata;
  logic              sdram_read_en;
  logic              sdram_write_en;
  logic [DATA_W-1:0] sdram_rdata;
  logic              sdram_ack;
  logic              busy;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .MAX_BURST      (MAX_BURST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk            (clk),
    .i_n_rst          (n_rst),
    .i_rd_req         (rd_req),
    .i_rd_addr        (rd_addr),
    .o_rd_gnt         (rd_gnt),
    .o_rd_data        (rd_data),
    .i_wr_req         (wr_req),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .o_wr_gnt         (wr_gnt),
    .o_sdram_addr     (sdram_addr),
    .o_sdram_wdata    (sdram_wdata),
    .o_sdram_read_en  (sdram_read_en),
    .o_sdram_write_en (sdram_write_en),
    .i_sdram_rdata    (sdram_rdata),
    .i_sdram_ack      (sdram_ack),
`ifdef SDRAM_ARB_TIMEOUT_EN
    .o_timeout_err    (timeout_err),
`endif
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ngr;
    int last_c;
    int cnt;
    logic seen;

    n_rst       = 1'b0;
    rd_req      = 1'b0;
    rd_addr     = 26'h0;
    wr_req      = 1'b0;
    wr_addr     = 26'h0;
    wr_data     = 32'h0;
    sdram_rdata = 32'h0;
    sdram_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_read_en",  sdram_read_en,  1'b0);
    check("rst_write_en", sdram_write_en, 1'b0);
    check("rst_rd_gnt",   rd_gnt,         1'b0);
    check("rst_wr_gnt",   wr_gnt,         1'b0);
    check("rst_busy",     busy,           1'b0);
    check("rst_rd_data",  rd_data,        32'h0);
    check("rst_addr",     sdram_addr,     26'h0);
    check("rst_wdata",    sdram_wdata,    32'h0);
    n_rst = 1'b1;

    // 1: single read, ack in the first command cycle
    rd_req      = 1'b1;
    rd_addr     = 26'h0000100;
    sdram_ack   = 1'b1;
    sdram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_c1_read_en",  sdram_read_en,  1'b1);
    check("t1_c1_write_en", sdram_write_en, 1'b0);
    check("t1_c1_addr",     sdram_addr,     26'h0000100);
    check("t1_c1_busy",     busy,           1'b1);
    check("t1_c1_rd_gnt",   rd_gnt,         1'b0);
    @(negedge clk);
    check("t1_c2_rd_gnt",   rd_gnt,         1'b1);
    check("t1_c2_rd_data",  rd_data,        32'hDEADBEEF);
    check("t1_c2_read_en",  sdram_read_en,  1'b0);
    check("t1_c2_busy",     busy,           1'b1);
    rd_req    = 1'b0;
    sdram_ack = 1'b0;
    @(negedge clk);
    check("t1_c3_busy",     busy,           1'b0);
    check("t1_c3_rd_gnt",   rd_gnt,         1'b0);
    check("t1_c3_rd_hold",  rd_data,        32'hDEADBEEF);

    // Stray ack while idle is ignored
    sdram_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_ack_busy",   busy,   1'b0);
    check("stray_ack_rd_gnt", rd_gnt, 1'b0);
    check("stray_ack_wr_gnt", wr_gnt, 1'b0);
    sdram_ack = 1'b0;

    // 2: both requesters from reset, immediate acks: R x8, W x8, R x8
    n_rst = 1'b0;
    @(negedge clk);
    n_rst       = 1'b1;
    rd_addr     = 26'h0001000;
    wr_addr     = 26'h0002000;
    wr_data     = 32'hA5A50001;
    sdram_rdata = 32'h0BADF00D;
    rd_req      = 1'b1;
    wr_req      = 1'b1;
    sdram_ack   = 1'b1;
    ngr = 0;
    for (int c = 0; c < 200 && ngr < 24; c++) begin
      @(negedge clk);
      check("t2_exclusive", sdram_read_en & sdram_write_en, 1'b0);
      if (sdram_read_en) begin
        check("t2_rd_addr", sdram_addr, 26'h0001000);
      end
      if (sdram_write_en) begin
        check("t2_wr_addr",  sdram_addr,  26'h0002000);
        check("t2_wr_wdata", sdram_wdata, 32'hA5A50001);
      end
      if (rd_gnt | wr_gnt) begin
        check($sformatf("t2_order_%0d", ngr), {rd_gnt, wr_gnt},
              (ngr >= 8 && ngr < 16) ? 2'b01 : 2'b10);
        if (rd_gnt) begin
          check("t2_rd_data", rd_data, 32'h0BADF00D);
        end
        ngr++;
        if (ngr == 24) begin
          rd_req = 1'b0;
          wr_req = 1'b0;
        end
      end
    end
    check("t2_grant_count", ngr, 24);

    // 3: writer alone for 20 accesses, one grant every 3 cycles
    wr_req  = 1'b1;
    wr_addr = 26'h0003300;
    wr_data = 32'h13572468;
    ngr     = 0;
    last_c  = 0;
    for (int c = 0; c < 200 && ngr < 20; c++) begin
      @(negedge clk);
      check("t3_no_rd_gnt", rd_gnt, 1'b0);
      if (wr_gnt) begin
        if (ngr > 0) begin
          check("t3_spacing", c - last_c, 3);
        end
        last_c = c;
        ngr++;
        if (ngr == 20) begin
          wr_req = 1'b0;
        end
      end
    end
    check("t3_grant_count", ngr, 20);
    sdram_ack = 1'b0;

    // 4: delayed ack, request dropped mid-access
    @(negedge clk);
    check("t4_idle_busy", busy, 1'b0);
    rd_req  = 1'b1;
    rd_addr = 26'h3ABCDEF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t4_read_en_%0d", k), sdram_read_en, 1'b1);
      check("t4_rd_gnt_early", rd_gnt, 1'b0);
      check("t4_addr_hold", sdram_addr, 26'h3ABCDEF);
      if (k == 2) begin
        rd_req = 1'b0;
      end
      if (k == 10) begin
        sdram_ack   = 1'b1;
        sdram_rdata = 32'h12345678;
      end
    end
    @(negedge clk);
    check("t4_read_en_drop", sdram_read_en, 1'b0);
    check("t4_rd_gnt",       rd_gnt,        1'b1);
    check("t4_rd_data",      rd_data,       32'h12345678);
    sdram_ack = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd_gnt) cnt++;
    end
    check("t4_single_gnt", cnt, 0);
    check("t4_busy_end",   busy, 1'b0);

    // 5: reset during a write, then first tie goes to read
    wr_req  = 1'b1;
    wr_addr = 26'h00000FF;
    wr_data = 32'h5555AAAA;
    @(negedge clk);
    check("t5_write_en", sdram_write_en, 1'b1);
    @(negedge clk);
    n_rst  = 1'b0;
    rd_req = 1'b1;
    #1;
    check("t5_async_drop", sdram_write_en, 1'b0);
    check("t5_rst_busy",   busy,           1'b0);
    @(negedge clk);
    check("t5_no_wr_gnt_rst", wr_gnt, 1'b0);
    n_rst       = 1'b1;
    sdram_ack   = 1'b1;
    sdram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("t5_tie_read_en",  sdram_read_en,  1'b1);
    check("t5_tie_write_en", sdram_write_en, 1'b0);
    check("t5_no_wr_gnt",    wr_gnt,         1'b0);
    @(negedge clk);
    check("t5_rd_gnt",    rd_gnt,  1'b1);
    check("t5_wr_gnt",    wr_gnt,  1'b0);
    check("t5_rd_data",   rd_data, 32'hCAFEF00D);
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    sdram_ack = 1'b0;
    @(negedge clk);
    check("t5_busy_end", busy, 1'b0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // 6: read never acked, watchdog aborts it
    rd_req  = 1'b1;
    rd_addr = 26'h0000ABC;
    cnt     = 0;
    seen    = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (sdram_read_en) cnt++;
      if (rd_gnt) begin
        seen = 1'b1;
        check("t6_timeout_err", timeout_err,   1'b1);
        check("t6_rd_data",     rd_data,       32'h0);
        check("t6_read_en",     sdram_read_en, 1'b0);
        rd_req = 1'b0;
      end else begin
        check("t6_err_idle", timeout_err, 1'b0);
      end
    end
    check("t6_gnt_seen",    seen, 1'b1);
    check("t6_read_cycles", cnt,  TIMEOUT_CYCLES);
    @(negedge clk);
    check("t6_err_pulse", timeout_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
